// File: rtl/irq_trap_ctrl.sv
// rtl/irq_trap_ctrl.sv - machine-mode interrupt/trap controller with CSRs, flush and fetch redirect
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   ext_irq, timer_irq  level-sensitive interrupt lines
//   ValidM, PCM, MretM  MEM-stage instruction valid flag, its PC, and whether it is mret
//   csr_we/waddr/wdata  CSR write port from writeback
//   csr_raddr/rdata     combinational CSR read port
//   Int_flush           flush every pipeline register this cycle
//   PCRedirectEn/PCRedirect  fetch redirect request and target
//   irq_pending         high while a trap waits for a real instruction in MEM
module irq_trap_ctrl #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        ValidM,
    input  logic [31:0] PCM,
    input  logic        MretM,
    input  logic        csr_we,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic        Int_flush,
    output logic        PCRedirectEn,
    output logic [31:0] PCRedirect,
    output logic        irq_pending
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_meie;
    logic        mie_mtie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;

    logic        take;
    logic        trap_fire;
    logic        mret_fire;
    logic [31:0] cause;

    assign take  = mstatus_mie & ((ext_irq & mie_meie) | (timer_irq & mie_mtie));
    // Sampled in the flush cycle; if both lines have dropped by then the
    // trap still happens and is reported as a timer interrupt.
    assign cause = (ext_irq & mie_meie) ? CAUSE_EXT : CAUSE_TIMER;

    assign irq_pending = (state == PENDING);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        Int_flush    = 1'b0;
        PCRedirectEn = 1'b0;
        PCRedirect   = 32'h0;
        trap_fire    = 1'b0;
        mret_fire    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state_nxt = PENDING;
                    end
                    if (MretM && ValidM) begin
                        mret_fire    = 1'b1;
                        Int_flush    = 1'b1;
                        PCRedirectEn = 1'b1;
                        PCRedirect   = mepc;
                    end
                end
                PENDING: begin
                    // Wait for a real instruction so mepc always names one
                    // that will be re-executed after the handler returns.
                    if (ValidM) begin
                        trap_fire    = 1'b1;
                        Int_flush    = 1'b1;
                        PCRedirectEn = 1'b1;
                        PCRedirect   = mtvec;
                        state_nxt    = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mie_mtie     <= 1'b0;
            mtvec        <= RESET_MTVEC & ALIGN_MASK;
            mepc         <= 32'h0;
            mcause       <= 32'h0;
        end else begin
            if (csr_we) begin
                case (csr_waddr)
                    ADDR_MSTATUS: begin
                        if (!trap_fire && !mret_fire) begin
                            mstatus_mie  <= csr_wdata[3];
                            mstatus_mpie <= csr_wdata[7];
                        end
                    end
                    ADDR_MIE: begin
                        mie_meie <= csr_wdata[11];
                        mie_mtie <= csr_wdata[7];
                    end
                    ADDR_MTVEC: mtvec <= csr_wdata & ALIGN_MASK;
                    ADDR_MEPC: begin
                        if (!trap_fire) begin
                            mepc <= csr_wdata & ALIGN_MASK;
                        end
                    end
                    ADDR_MCAUSE: begin
                        if (!trap_fire) begin
                            mcause <= csr_wdata;
                        end
                    end
                    default: ;
                endcase
            end
            if (trap_fire) begin
                mepc         <= PCM & ALIGN_MASK;
                mcause       <= cause;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end
            if (mret_fire) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
        end
    end

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_raddr)
            ADDR_MSTATUS: begin
                csr_rdata[3] = mstatus_mie;
                csr_rdata[7] = mstatus_mpie;
            end
            ADDR_MIE: begin
                csr_rdata[11] = mie_meie;
                csr_rdata[7]  = mie_mtie;
            end
            ADDR_MTVEC:  csr_rdata = mtvec;
            ADDR_MEPC:   csr_rdata = mepc;
            ADDR_MCAUSE: csr_rdata = mcause;
            ADDR_MIP: begin
                csr_rdata[11] = ext_irq;
                csr_rdata[7]  = timer_irq;
            end
            default: csr_rdata = 32'h0;
        endcase
    end

endmodule

// File: doc/irq_trap_ctrl.md
Name: irq_trap_ctrl

Overview:
Machine-mode interrupt and trap controller for the 5-stage RV32 pipeline. It is the producer of Int_flush, the signal that every pipeline register consumes.
- Holds the interrupt CSRs.
- Arbitrates pending interrupts at an instruction boundary in the MEM stage.
- Flushes the pipeline, captures mepc/mcause and redirects fetch to mtvec.
- Handles mret by redirecting fetch to mepc.

Parameters:
RESET_MTVEC, 32'h0000_0000, mtvec reset value (bits [1:0] forced 0, direct mode only)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ext_irq  in  1  external interrupt line, level
timer_irq  in  1  timer interrupt line, level
ValidM  in  1  MEM stage holds a real (non-bubble) instruction
PCM  in  32  PC of MEM-stage instruction
MretM  in  1  MEM-stage instruction is mret
csr_we  in  1  CSR write from writeback
csr_waddr  in  12  CSR write address
csr_wdata  in  32  CSR write data
csr_raddr  in  12  CSR read address
csr_rdata  out  32  CSR read data, combinational
Int_flush  out  1  flush all pipeline registers this cycle
PCRedirectEn  out  1  fetch takes PCRedirect at next edge
PCRedirect  out  32  redirect target
irq_pending  out  1  registered: state is PENDING

Behaviour:
CSRs (all reset to 0 except mtvec):
- mstatus 0x300: only MIE[3] and MPIE[7] are implemented; other bits read 0.
- mie 0x304: MEIE[11] and MTIE[7].
- mtvec 0x305: reset RESET_MTVEC; bits [1:0] read 0.
- mepc 0x341: bits [1:0] read 0.
- mcause 0x342.
- mip 0x344: read-only. MEIP[11]=ext_irq, MTIP[7]=timer_irq. Writes are ignored.
- Unimplemented addresses read 0; writes to them are ignored.

take = mstatus.MIE & ((ext_irq & MEIE) | (timer_irq & MTIE)).

FSM states: IDLE, PENDING.
- IDLE, take=1: go to PENDING at next edge. mret handling in the same cycle still applies.
- PENDING, ValidM=0: stay in PENDING. Outputs are quiet.
- PENDING, ValidM=1, comb outputs:
  - Int_flush=1, PCRedirectEn=1, PCRedirect=mtvec.
- PENDING, ValidM=1, at the edge:
  - mepc<=PCM; mcause<=cause; MPIE<=MIE; MIE<=0; state<=IDLE.
  - The flushed MEM instruction re-executes after the handler.
- cause is evaluated in that cycle: 32'h8000_000B if ext is enabled and pending, else 32'h8000_0007.
- Lines deasserting while in PENDING do not cancel the trap. If neither line is pending at the flush cycle, cause is 32'h8000_0007.

mret (only when state=IDLE and MretM&ValidM):
- Comb: Int_flush=1, PCRedirectEn=1, PCRedirect=mepc.
- Edge: MIE<=MPIE; MPIE<=1.
- In PENDING an mret is not executed. It is flushed as the trapped instruction, and mepc = the mret's PC.

Default outputs: Int_flush=0, PCRedirectEn=0, PCRedirect=0.

Priority and simultaneous events:
- A hardware trap or mret update to mstatus/mepc/mcause wins over a csr_we write to the same CSR in the same cycle.
- A CSR write to mie/mtvec in a flush cycle still takes effect.
- A write to mstatus.MIE=1 in IDLE with a pending enabled line: PENDING is entered the cycle after the write lands.
- Back-to-back traps are impossible without software re-enabling, because MIE=0 after a trap.

Reset:
- rst in any state (including PENDING with ValidM=1): state<=IDLE and all CSRs are reset.
- Int_flush and PCRedirectEn are forced 0 during the rst cycle.
- irq_pending=0.

Test Plan:
- Enable timer interrupt: rst, write mtvec=0x100, mie=0x80, mstatus=0x8; raise timer_irq with ValidM=1, PCM=0x40 -> irq_pending next cycle. Following cycle: Int_flush=1, PCRedirect=0x100. Afterwards: mepc=0x40, mcause=0x80000007, mstatus=0x80.
- Both lines with both enabled (mie=0x880) -> mcause=0x8000000B.
- Bubble wait: PENDING with ValidM=0 for 3 cycles, then ValidM=1, PCM=0x58 -> Int_flush exactly once, in the 4th cycle; mepc=0x58.
- mret in IDLE: mepc=0x44, MPIE=1, MretM=ValidM=1 -> Int_flush=1, PCRedirect=0x44 the same cycle; mstatus=0x88 next cycle.
- Collision: csr_we to mepc=0x999 in the trap-flush cycle with PCM=0x60 -> mepc=0x60. Write to mip -> mip still mirrors the lines.
- rst asserted while PENDING with ValidM=1 -> Int_flush=0 that cycle. Next cycle: irq_pending=0, mtvec=RESET_MTVEC, all other CSRs 0.
